// File: rtl/imem_loader.sv
// imem_loader
// Loads a program into instruction memory from a byte stream before the CPU runs.
// The stream is a 16-bit big-endian word count N, followed by N big-endian
// 32-bit words. The words are written to consecutive addresses starting at
// BASE_ADDR, and the address wraps modulo 2**ADDR_W.
//
// Ports:
//   ref_clk        - system clock, rising edge
//   reset          - synchronous, active-high
//   start          - begin a load (only honoured in IDLE, DONE, ERR)
//   byte_valid     - source presents byte_data
//   byte_data      - stream byte
//   byte_ready     - loader accepts a byte this cycle (transfer = valid && ready)
//   imem_we        - single-cycle instruction-memory write strobe
//   imem_addr      - word address of the write
//   imem_wdata     - word written
//   cpu_reset_hold - 1 keeps the processor in reset
//   done           - load finished successfully (level)
//   error          - header count exceeded memory depth (level)
module imem_loader #(
    parameter int                 ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    // One extra bit so that a count equal to the full depth is representable.
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              byte_ready_q, byte_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       n_new;

    assign accept = byte_ready_q && byte_valid;
    // Full word count once the low header byte is accepted.
    assign n_new  = {n_q[15:8], byte_data};

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        asm_d        = asm_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = HDR_HI;
                    n_d        = '0;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    asm_d      = '0;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    n_d     = {byte_data, n_q[7:0]};
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    n_d = n_new;
                    if ({1'b0, n_new} > DEPTH) begin
                        state_d = ERR;
                    end else if (n_new == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    asm_d      = {asm_q[15:0], byte_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // The fourth byte completes the word. The data and address
                    // are registered now so that both are valid together with the strobe.
                    if (byte_cnt_q == 2'd3) begin
                        state_d      = WRITE;
                        imem_wdata_d = {asm_q, byte_data};
                        imem_addr_d  = BASE_ADDR + word_idx_q[ADDR_W-1:0];
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (word_idx_q + 16'd1 == n_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            default: state_d = IDLE;
        endcase

        // The outputs are decoded from the next state so that the registered
        // values line up with the state the FSM is in.
        byte_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
        imem_we_d    = (state_d == WRITE);
        hold_d       = (state_d != DONE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            n_q          <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            asm_q        <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            asm_q        <= asm_d;
            byte_ready_q <= byte_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            hold_q       <= hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready     = byte_ready_q;
    assign imem_we        = imem_we_q;
    assign imem_addr      = imem_addr_q;
    assign imem_wdata     = imem_wdata_q;
    assign cpu_reset_hold = hold_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. It uses two instances: dut0 with BASE_ADDR=0 and
// dut1 with BASE_ADDR=254. The sel signal routes the shared stimulus to one
// instance and selects which instance's outputs are observed. A monitor
// compares every write strobe against a queue of expected writes that is filled
// when the stimulus is driven.
module tb_imem_loader;

    logic       ref_clk = 1'b0;
    logic       reset;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       sel;

    logic       ready0, we0, hold0, done0, err0;
    logic [7:0] addr0;
    logic [31:0] wdata0;
    logic       ready1, we1, hold1, done1, err1;
    logic [7:0] addr1;
    logic [31:0] wdata1;

    logic       ready_m, we_m, hold_m, done_m, err_m;
    logic [7:0] addr_m;
    logic [31:0] wdata_m;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wr_count = 0;

    always #5 ref_clk = ~ref_clk;

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut0 (
        .ref_clk(ref_clk), .reset(reset),
        .start(start && !sel), .byte_valid(byte_valid && !sel), .byte_data(byte_data),
        .byte_ready(ready0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .cpu_reset_hold(hold0), .done(done0), .error(err0)
    );

    imem_loader #(.ADDR_W(8), .BASE_ADDR(8'd254)) dut1 (
        .ref_clk(ref_clk), .reset(reset),
        .start(start && sel), .byte_valid(byte_valid && sel), .byte_data(byte_data),
        .byte_ready(ready1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .cpu_reset_hold(hold1), .done(done1), .error(err1)
    );

    assign ready_m = sel ? ready1 : ready0;
    assign we_m    = sel ? we1    : we0;
    assign hold_m  = sel ? hold1  : hold0;
    assign done_m  = sel ? done1  : done0;
    assign err_m   = sel ? err1   : err0;
    assign addr_m  = sel ? addr1  : addr0;
    assign wdata_m = sel ? wdata1 : wdata0;

    // Each strobe must match the oldest expected write. A strobe that lasts
    // more than one cycle, or a strobe nobody expected, finds the wrong entry
    // or an empty queue.
    always @(negedge ref_clk) begin
        if (we_m === 1'b1) begin
            wr_t e;
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write addr=%0d data=%h (no write expected)", addr_m, wdata_m);
            end else begin
                e = exp_q.pop_front();
                if (addr_m !== e.addr || wdata_m !== e.data) begin
                    errors++;
                    $display("[TB] FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             addr_m, wdata_m, e.addr, e.data);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge ref_clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input bit with_valid);
        start = 1'b1;
        if (with_valid) begin
            byte_valid = 1'b1;
            byte_data  = 8'hFF;
        end
        @(negedge ref_clk);
        start = 1'b0;
        byte_valid = 1'b0;
    endtask

    // Called at a negedge and returns at the negedge that follows the edge on
    // which the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(negedge ref_clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (ready_m !== 1'b1 && n < 20) begin
            @(negedge ref_clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_ready_timeout got ready=%b expected 1 within 20 cycles", ready_m);
        end
        @(negedge ref_clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [7:0] a, input bit gaps);
        wr_t e;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gaps);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_m !== 1'b1 && n < budget) begin
            @(negedge ref_clk);
            n++;
        end
        checks++;
        if (done_m !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout got done=%b expected 1", name, done_m);
        end
    endtask

    task automatic test_reset();
        int w0;
        sel = 1'b0;
        do_reset();
        checks++; if (hold_m !== 1'b1)  begin errors++; $display("[TB] FAIL reset_hold got %b expected 1", hold_m); end
        checks++; if (done_m !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done_m); end
        checks++; if (err_m !== 1'b0)   begin errors++; $display("[TB] FAIL reset_error got %b expected 0", err_m); end
        checks++; if (ready_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", ready_m); end
        checks++; if (we_m !== 1'b0)    begin errors++; $display("[TB] FAIL reset_we got %b expected 0", we_m); end
        checks++; if (addr_m !== 8'd0)  begin errors++; $display("[TB] FAIL reset_addr got %0d expected 0", addr_m); end
        checks++; if (addr1 !== 8'd254) begin errors++; $display("[TB] FAIL reset_addr_base got %0d expected 254", addr1); end
        w0 = wr_count;
        for (int i = 0; i < 8; i++) begin
            byte_valid = i[0];
            byte_data  = 8'(i * 17);
            @(negedge ref_clk);
        end
        byte_valid = 1'b0;
        checks++; if (wr_count != w0)   begin errors++; $display("[TB] FAIL idle_writes got %0d expected 0", wr_count - w0); end
        checks++; if (ready_m !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready got %b expected 0", ready_m); end
    endtask

    task automatic test_two_word();
        sel = 1'b0;
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'h12345678, 8'd0, 1'b0);
        send_word(32'h9ABCDEF0, 8'd1, 1'b0);
        // The second strobe is visible here. done must rise exactly one cycle later.
        checks++; if (done_m !== 1'b0) begin errors++; $display("[TB] FAIL two_word_done_early got %b expected 0", done_m); end
        @(negedge ref_clk);
        checks++; if (done_m !== 1'b1) begin errors++; $display("[TB] FAIL two_word_done got %b expected 1", done_m); end
        checks++; if (hold_m !== 1'b0) begin errors++; $display("[TB] FAIL two_word_hold got %b expected 0", hold_m); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL two_word_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_zero_count();
        int w0 = wr_count;
        sel = 1'b0;
        // The 0xFF byte offered together with start must be ignored.
        pulse_start(1'b1);
        checks++; if (hold_m !== 1'b1) begin errors++; $display("[TB] FAIL zero_hold_reassert got %b expected 1", hold_m); end
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++; if (done_m !== 1'b1) begin errors++; $display("[TB] FAIL zero_done got %b expected 1", done_m); end
        checks++; if (hold_m !== 1'b0) begin errors++; $display("[TB] FAIL zero_hold got %b expected 0", hold_m); end
        checks++; if (wr_count != w0)  begin errors++; $display("[TB] FAIL zero_writes got %0d expected 0", wr_count - w0); end
    endtask

    task automatic test_overflow();
        int w0 = wr_count;
        sel = 1'b0;
        pulse_start(1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        checks++; if (err_m !== 1'b1)   begin errors++; $display("[TB] FAIL ovf_error got %b expected 1", err_m); end
        checks++; if (hold_m !== 1'b1)  begin errors++; $display("[TB] FAIL ovf_hold got %b expected 1", hold_m); end
        checks++; if (ready_m !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready got %b expected 0", ready_m); end
        checks++; if (done_m !== 1'b0)  begin errors++; $display("[TB] FAIL ovf_done got %b expected 0", done_m); end
        checks++; if (wr_count != w0)   begin errors++; $display("[TB] FAIL ovf_writes got %0d expected 0", wr_count - w0); end
        pulse_start(1'b0);
        checks++; if (err_m !== 1'b0)   begin errors++; $display("[TB] FAIL ovf_error_clear got %b expected 0", err_m); end
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            send_word({iv, ~iv, iv ^ 8'h5A, 8'hC3}, iv, 1'b0);
        end
        wait_done(4, "full");
        checks++; if (wr_count - w0 != 256) begin errors++; $display("[TB] FAIL full_writes got %0d expected 256", wr_count - w0); end
        checks++; if (exp_q.size() != 0)    begin errors++; $display("[TB] FAIL full_pending got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_stall_wrap();
        int w0 = wr_count;
        logic [7:0] a;
        sel = 1'b1;
        pulse_start(1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        for (int i = 0; i < 3; i++) begin
            a = 8'(254 + i);
            send_word(32'hC0DE0000 | (32'(i) << 8) | 32'(i * 3 + 1), a, 1'b1);
        end
        wait_done(4, "wrap");
        checks++; if (wr_count - w0 != 3) begin errors++; $display("[TB] FAIL wrap_writes got %0d expected 3", wr_count - w0); end
        checks++; if (hold_m !== 1'b0)    begin errors++; $display("[TB] FAIL wrap_hold got %b expected 0", hold_m); end
    endtask

    task automatic test_reset_mid_word();
        int w0 = wr_count;
        sel = 1'b1;
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b1;
        @(negedge ref_clk);
        reset = 1'b0;
        checks++; if (we_m !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_we got %b expected 0", we_m); end
        checks++; if (hold_m !== 1'b1)   begin errors++; $display("[TB] FAIL midrst_hold got %b expected 1", hold_m); end
        checks++; if (ready_m !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_ready got %b expected 0", ready_m); end
        checks++; if (addr_m !== 8'd254) begin errors++; $display("[TB] FAIL midrst_addr got %0d expected 254", addr_m); end
        repeat (3) @(negedge ref_clk);
        checks++; if (wr_count != w0)    begin errors++; $display("[TB] FAIL midrst_writes got %0d expected 0", wr_count - w0); end
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'hAABBCCDD, 8'd254, 1'b0);
        wait_done(4, "midrst_reload");
        checks++; if (wr_count - w0 != 1) begin errors++; $display("[TB] FAIL midrst_reload_writes got %0d expected 1", wr_count - w0); end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        sel        = 1'b0;
        @(negedge ref_clk);
        test_reset();
        test_two_word();
        test_zero_count();
        test_overflow();
        test_stall_wrap();
        test_reset_mid_word();
        repeat (3) @(negedge ref_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL final_pending got %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
